// File: rtl/ls_exec_unit.sv
// Load/store execution stage: one memory op in flight, effective address rs1+imm,
// load extension and broadcast, store address-ready report then commit-gated write.
module ls_exec_unit #(
  parameter int              OP_W   = 6,
  parameter int              ROB_W  = 4,
  parameter logic [OP_W-1:0] OP_LB  = OP_W'(10),
  parameter logic [OP_W-1:0] OP_LH  = OP_W'(11),
  parameter logic [OP_W-1:0] OP_LW  = OP_W'(12),
  parameter logic [OP_W-1:0] OP_LBU = OP_W'(13),
  parameter logic [OP_W-1:0] OP_LHU = OP_W'(14),
  parameter logic [OP_W-1:0] OP_SB  = OP_W'(15),
  parameter logic [OP_W-1:0] OP_SH  = OP_W'(16),
  parameter logic [OP_W-1:0] OP_SW  = OP_W'(17)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  output logic             LSB_ready,
  input  logic             LSB_input_valid,
  input  logic [OP_W-1:0]  LSB_OP_ID,
  input  logic [31:0]      LSB_inst_pc,
  input  logic [31:0]      LSB_reg_rs1,
  input  logic [31:0]      LSB_reg_rs2,
  input  logic [31:0]      LSB_imm,
  input  logic [ROB_W-1:0] LSB_ROB_id,
  output logic             ROB_output_valid,
  output logic [ROB_W-1:0] ROB_output_id,
  output logic [31:0]      ROB_output_value,
  output logic             ROB_output_is_store,
  input  logic             ROB_store_commit,
  input  logic [ROB_W-1:0] ROB_store_id,
  input  logic             ROB_roll_back_flag,
  output logic             MC_req_valid,
  output logic             MC_req_wr,
  output logic [31:0]      MC_req_addr,
  output logic [1:0]       MC_req_size,
  output logic [31:0]      MC_req_wdata,
  input  logic             MC_done,
  input  logic [31:0]      MC_rdata
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_MEM   = 3'd1;
  localparam logic [2:0] S_LOAD_FLUSH = 3'd2;
  localparam logic [2:0] S_STORE_WAIT = 3'd3;
  localparam logic [2:0] S_STORE_MEM  = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic             r_ready;
  logic [OP_W-1:0]  r_op;
  logic [ROB_W-1:0] r_tag;
  logic [31:0]      r_rs2, r_addr, r_pc;
  logic [1:0]       r_size;

  logic [31:0] w_addr;
  logic        w_accept, w_commit, w_is_load, w_is_store;
  logic [1:0]  w_size_in;

  function automatic logic [1:0] f_size(input logic [OP_W-1:0] op);
    if (op == OP_LH || op == OP_LHU || op == OP_SH)      f_size = 2'd1;
    else if (op == OP_LW || op == OP_SW)                 f_size = 2'd2;
    else                                                 f_size = 2'd0;
  endfunction

  function automatic logic [31:0] f_ext(input logic [OP_W-1:0] op, input logic [31:0] d);
    if      (op == OP_LB)  f_ext = {{24{d[7]}}, d[7:0]};
    else if (op == OP_LH)  f_ext = {{16{d[15]}}, d[15:0]};
    else if (op == OP_LBU) f_ext = {24'h0, d[7:0]};
    else if (op == OP_LHU) f_ext = {16'h0, d[15:0]};
    else if (op == OP_LW)  f_ext = d;
    else                   f_ext = 32'h0;
  endfunction

  function automatic logic [31:0] f_mask(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    f_mask = {24'h0, d[7:0]};
      2'd1:    f_mask = {16'h0, d[15:0]};
      default: f_mask = d;
    endcase
  endfunction

  assign w_addr     = LSB_reg_rs1 + LSB_imm;
  assign w_accept   = LSB_input_valid & r_ready & ~ROB_roll_back_flag;
  assign w_commit   = ROB_store_commit & (ROB_store_id == r_tag);
  assign w_is_load  = (LSB_OP_ID == OP_LB) || (LSB_OP_ID == OP_LH) || (LSB_OP_ID == OP_LW) ||
                      (LSB_OP_ID == OP_LBU) || (LSB_OP_ID == OP_LHU);
  assign w_is_store = (LSB_OP_ID == OP_SB) || (LSB_OP_ID == OP_SH) || (LSB_OP_ID == OP_SW);
  assign w_size_in  = f_size(LSB_OP_ID);
  assign LSB_ready  = r_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_load)       w_state_nxt = S_LOAD_MEM;
        else if (w_accept && w_is_store) w_state_nxt = S_STORE_WAIT;
      end
      // A completion coinciding with a flush is simply dropped, so done wins here.
      S_LOAD_MEM: begin
        if (MC_done)                 w_state_nxt = S_IDLE;
        else if (ROB_roll_back_flag) w_state_nxt = S_LOAD_FLUSH;
      end
      S_LOAD_FLUSH: if (MC_done) w_state_nxt = S_IDLE;
      S_STORE_WAIT: begin
        if (w_commit)                w_state_nxt = S_STORE_MEM;
        else if (ROB_roll_back_flag) w_state_nxt = S_IDLE;
      end
      S_STORE_MEM:  if (MC_done) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= S_IDLE;
      r_ready             <= 1'b0;
      r_op                <= '0;
      r_tag               <= '0;
      r_rs2               <= '0;
      r_addr              <= '0;
      r_pc                <= '0;
      r_size              <= '0;
      ROB_output_valid    <= 1'b0;
      ROB_output_id       <= '0;
      ROB_output_value    <= '0;
      ROB_output_is_store <= 1'b0;
      MC_req_valid        <= 1'b0;
      MC_req_wr           <= 1'b0;
      MC_req_addr         <= '0;
      MC_req_size         <= '0;
      MC_req_wdata        <= '0;
    end else if (rdy) begin
      r_state             <= w_state_nxt;
      r_ready             <= (w_state_nxt == S_IDLE) && !w_accept;
      ROB_output_valid    <= 1'b0;
      ROB_output_is_store <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= LSB_OP_ID;
          r_tag  <= LSB_ROB_id;
          r_rs2  <= LSB_reg_rs2;
          r_addr <= w_addr;
          r_pc   <= LSB_inst_pc;
          r_size <= w_size_in;
          if (w_is_load) begin
            MC_req_valid <= 1'b1;
            MC_req_wr    <= 1'b0;
            MC_req_addr  <= w_addr;
            MC_req_size  <= w_size_in;
            MC_req_wdata <= '0;
          end else begin
            // Stores report address-ready; unknown ops retire as a zero result.
            ROB_output_valid    <= 1'b1;
            ROB_output_is_store <= w_is_store;
            ROB_output_value    <= '0;
            ROB_output_id       <= LSB_ROB_id;
          end
        end
        S_LOAD_MEM: if (MC_done) begin
          MC_req_valid <= 1'b0;
          if (!ROB_roll_back_flag) begin
            ROB_output_valid <= 1'b1;
            ROB_output_value <= f_ext(r_op, MC_rdata);
            ROB_output_id    <= r_tag;
          end
        end
        S_LOAD_FLUSH: if (MC_done) MC_req_valid <= 1'b0;
        S_STORE_WAIT: if (w_commit) begin
          MC_req_valid <= 1'b1;
          MC_req_wr    <= 1'b1;
          MC_req_addr  <= r_addr;
          MC_req_size  <= r_size;
          MC_req_wdata <= f_mask(r_size, r_rs2);
        end
        S_STORE_MEM: if (MC_done) begin
          MC_req_valid <= 1'b0;
          MC_req_wr    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_exec_unit.sv
// Self-checking bench for ls_exec_unit: directed scenarios plus randomized ops
// checked against a transaction-level model of addressing, sizing and extension.
module tb_ls_exec_unit;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic        LSB_ready, LSB_input_valid = 1'b0;
  logic [5:0]  LSB_OP_ID = '0;
  logic [31:0] LSB_inst_pc = '0, LSB_reg_rs1 = '0, LSB_reg_rs2 = '0, LSB_imm = '0;
  logic [3:0]  LSB_ROB_id = '0;
  logic        ROB_output_valid, ROB_output_is_store;
  logic [3:0]  ROB_output_id;
  logic [31:0] ROB_output_value;
  logic        ROB_store_commit = 1'b0, ROB_roll_back_flag = 1'b0;
  logic [3:0]  ROB_store_id = '0;
  logic        MC_req_valid, MC_req_wr;
  logic [31:0] MC_req_addr, MC_req_wdata;
  logic [1:0]  MC_req_size;
  logic        MC_done = 1'b0;
  logic [31:0] MC_rdata = '0;

  int n_vec = 0, n_err = 0;

  ls_exec_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .LSB_ready(LSB_ready),
    .LSB_input_valid(LSB_input_valid), .LSB_OP_ID(LSB_OP_ID), .LSB_inst_pc(LSB_inst_pc),
    .LSB_reg_rs1(LSB_reg_rs1), .LSB_reg_rs2(LSB_reg_rs2), .LSB_imm(LSB_imm),
    .LSB_ROB_id(LSB_ROB_id), .ROB_output_valid(ROB_output_valid),
    .ROB_output_id(ROB_output_id), .ROB_output_value(ROB_output_value),
    .ROB_output_is_store(ROB_output_is_store), .ROB_store_commit(ROB_store_commit),
    .ROB_store_id(ROB_store_id), .ROB_roll_back_flag(ROB_roll_back_flag),
    .MC_req_valid(MC_req_valid), .MC_req_wr(MC_req_wr), .MC_req_addr(MC_req_addr),
    .MC_req_size(MC_req_size), .MC_req_wdata(MC_req_wdata),
    .MC_done(MC_done), .MC_rdata(MC_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: op numbering 10..14 loads, 15..17 stores.
  function automatic bit m_is_load(input int op);  return op >= 10 && op <= 14; endfunction
  function automatic bit m_is_store(input int op); return op >= 15 && op <= 17; endfunction
  function automatic int m_bytes(input int op);
    if (op == 10 || op == 13 || op == 15) return 1;
    if (op == 11 || op == 14 || op == 16) return 2;
    if (op == 12 || op == 17) return 4;
    return 1;
  endfunction
  function automatic logic [31:0] m_size(input int op);
    return (m_bytes(op) == 1) ? 0 : (m_bytes(op) == 2) ? 1 : 2;
  endfunction
  function automatic logic [31:0] m_trunc(input int op, input logic [31:0] d);
    longint v = longint'(d);
    if (m_bytes(op) == 1) return 32'(v % 256);
    if (m_bytes(op) == 2) return 32'(v % 65536);
    return d;
  endfunction
  function automatic logic [31:0] m_load(input int op, input logic [31:0] d);
    longint v = longint'(m_trunc(op, d));
    if (op == 10 && v >= 128)   v = v - 256 + 64'h1_0000_0000;
    if (op == 11 && v >= 32768) v = v - 65536 + 64'h1_0000_0000;
    return 32'(v);
  endfunction
  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [31:0] b);
    return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
  endfunction

  task automatic issue(input int op, input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] rs2, input logic [3:0] tag);
    int n = 0;
    while (!LSB_ready && n < 50) begin tick(); n++; end
    chk("ready_wait", LSB_ready, 1);
    LSB_input_valid = 1'b1; LSB_OP_ID = 6'(op); LSB_reg_rs1 = rs1; LSB_imm = imm;
    LSB_reg_rs2 = rs2; LSB_ROB_id = tag; LSB_inst_pc = $urandom;
    tick();
    LSB_input_valid = 1'b0; LSB_OP_ID = 6'($urandom); LSB_reg_rs1 = $urandom;
    chk("ready_drop", LSB_ready, 0);
  endtask

  // mode: 0 normal, 1 rollback while waiting, 2 rollback together with done
  task automatic do_load(input int op, input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [3:0] tag, input int lat, input logic [31:0] rd, input int mode);
    logic [31:0] ea = m_addr(rs1, imm);
    issue(op, rs1, imm, 32'h0, tag);
    chk("ld_req_v", MC_req_valid, 1);
    chk("ld_req_wr", MC_req_wr, 0);
    chk("ld_req_addr", MC_req_addr, ea);
    chk("ld_req_size", MC_req_size, m_size(op));
    for (int i = 0; i < lat; i++) begin
      ROB_roll_back_flag = (mode == 1 && i == 0);
      tick();
      ROB_roll_back_flag = 1'b0;
      chk("ld_hold_v", MC_req_valid, 1);
      chk("ld_hold_addr", MC_req_addr, ea);
      chk("ld_no_pulse", ROB_output_valid, 0);
    end
    MC_done = 1'b1; MC_rdata = rd; ROB_roll_back_flag = (mode == 2);
    tick();
    MC_done = 1'b0; MC_rdata = $urandom; ROB_roll_back_flag = 1'b0;
    chk("ld_req_drop", MC_req_valid, 0);
    chk("ld_pulse", ROB_output_valid, (mode == 0));
    if (mode == 0) begin
      chk("ld_value", ROB_output_value, m_load(op, rd));
      chk("ld_id", ROB_output_id, tag);
      chk("ld_is_store", ROB_output_is_store, 0);
    end
    chk("ld_ready_after", LSB_ready, 1);
    tick();
    chk("ld_pulse_1cyc", ROB_output_valid, 0);
  endtask

  // mode: 0 normal, 1 wrong-id commit first, 2 rollback in wait, 3 commit+rollback,
  //       4 rollback during write, 5 rdy low with commit held
  task automatic do_store(input int op, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] rs2, input logic [3:0] tag, input int lat, input int mode);
    logic [31:0] ea = m_addr(rs1, imm);
    issue(op, rs1, imm, rs2, tag);
    chk("st_pulse", ROB_output_valid, 1);
    chk("st_is_store", ROB_output_is_store, 1);
    chk("st_value", ROB_output_value, 0);
    chk("st_id", ROB_output_id, tag);
    chk("st_no_req", MC_req_valid, 0);
    tick();
    chk("st_pulse_1cyc", ROB_output_valid, 0);
    if (mode == 1) begin
      ROB_store_commit = 1'b1; ROB_store_id = tag ^ 4'h1;
      tick();
      ROB_store_commit = 1'b0;
      chk("st_wrong_id", MC_req_valid, 0);
    end
    if (mode == 2) begin
      ROB_roll_back_flag = 1'b1;
      tick();
      ROB_roll_back_flag = 1'b0;
      chk("st_rb_noreq", MC_req_valid, 0);
      chk("st_rb_ready", LSB_ready, 1);
      tick();
      chk("st_rb_noreq2", MC_req_valid, 0);
      return;
    end
    ROB_store_commit = 1'b1; ROB_store_id = tag;
    if (mode == 5) begin
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("st_frozen_req", MC_req_valid, 0);
        chk("st_frozen_rdy", LSB_ready, 0);
      end
      rdy = 1'b1;
    end
    ROB_roll_back_flag = (mode == 3);
    tick();
    ROB_store_commit = 1'b0; ROB_roll_back_flag = 1'b0;
    chk("st_req_v", MC_req_valid, 1);
    chk("st_req_wr", MC_req_wr, 1);
    chk("st_req_addr", MC_req_addr, ea);
    chk("st_req_size", MC_req_size, m_size(op));
    chk("st_req_wdata", MC_req_wdata, m_trunc(op, rs2));
    for (int i = 0; i < lat; i++) begin
      ROB_roll_back_flag = (mode == 4 && i == 0);
      tick();
      ROB_roll_back_flag = 1'b0;
      chk("st_hold_v", MC_req_valid, 1);
      chk("st_no_pulse", ROB_output_valid, 0);
    end
    MC_done = 1'b1;
    tick();
    MC_done = 1'b0;
    chk("st_req_drop", MC_req_valid, 0);
    chk("st_done_nopulse", ROB_output_valid, 0);
    chk("st_ready_after", LSB_ready, 1);
  endtask

  initial begin
    #1;
    chk("rst_ready", LSB_ready, 0);
    chk("rst_rob_v", ROB_output_valid, 0);
    chk("rst_is_store", ROB_output_is_store, 0);
    chk("rst_mc_v", MC_req_valid, 0);
    chk("rst_mc_wr", MC_req_wr, 0);
    chk("rst_mc_addr", MC_req_addr, 0);
    chk("rst_rob_val", ROB_output_value, 0);
    @(posedge clk); #1; rst = 1'b1;
    tick();
    chk("rel_ready", LSB_ready, 1);

    do_load(12, 32'h1000, 32'hFFFFFFFC, 4'h5, 3, 32'hDEADBEEF, 0);
    do_load(10, 32'h40, 32'h0, 4'h1, 1, 32'h00000080, 0);
    do_load(13, 32'h40, 32'h1, 4'h2, 0, 32'h00000080, 0);
    do_load(11, 32'h40, 32'h2, 4'h3, 2, 32'h00008001, 0);
    do_store(15, 32'h2000, 32'h3, 32'h12345678, 4'h6, 2, 1);
    do_load(12, 32'h80, 32'h4, 4'h7, 3, 32'h11112222, 1);
    do_load(14, 32'h80, 32'h8, 4'h8, 2, 32'h0000F00F, 2);
    do_store(16, 32'h3000, 32'h2, 32'hCAFEBABE, 4'h9, 3, 4);
    do_store(17, 32'h3000, 32'h4, 32'hA5A5A5A5, 4'hA, 1, 2);
    do_store(17, 32'h3010, 32'h0, 32'h01020304, 4'hB, 1, 3);
    do_store(15, 32'h3020, 32'h1, 32'h000000FF, 4'hC, 1, 5);

    issue(63, 32'h10, 32'h20, 32'h30, 4'hD);
    chk("unk_pulse", ROB_output_valid, 1);
    chk("unk_value", ROB_output_value, 0);
    chk("unk_id", ROB_output_id, 4'hD);
    chk("unk_no_req", MC_req_valid, 0);
    tick();
    chk("unk_ready", LSB_ready, 1);

    ROB_roll_back_flag = 1'b1; LSB_input_valid = 1'b1; LSB_OP_ID = 6'd12;
    tick();
    ROB_roll_back_flag = 1'b0; LSB_input_valid = 1'b0;
    chk("rb_blocks_accept", MC_req_valid, 0);
    chk("rb_ready_kept", LSB_ready, 1);

    for (int t = 0; t < 60; t++) begin
      int k = $urandom_range(0, 8);
      int op = (k == 8) ? 63 : 10 + k;
      logic [31:0] rs1 = $urandom, imm = $urandom, rs2 = $urandom, rd = $urandom;
      logic [3:0] tag = 4'($urandom);
      int lat = $urandom_range(1, 4);
      if (m_is_load(op)) do_load(op, rs1, imm, tag, lat, rd, $urandom_range(0, 2));
      else if (m_is_store(op)) do_store(op, rs1, imm, rs2, tag, lat, $urandom_range(0, 5));
      else begin
        issue(op, rs1, imm, rs2, tag);
        chk("r_unk_pulse", ROB_output_valid, 1);
        chk("r_unk_id", ROB_output_id, tag);
        chk("r_unk_value", ROB_output_value, 0);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    issue(12, 32'h500, 32'h4, 32'h0, 4'h4);
    chk("ar_req_v", MC_req_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_mc_v", MC_req_valid, 0);
    chk("ar_rob_v", ROB_output_valid, 0);
    chk("ar_ready", LSB_ready, 0);
    chk("ar_addr", MC_req_addr, 0);
    @(posedge clk); #1; rst = 1'b1;
    tick();
    chk("ar_rel_ready", LSB_ready, 1);
    do_load(13, 32'h600, 32'h7, 4'h2, 1, 32'h000000C3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
